// File: rtl/terrain_crater_writer_if.sv
// Request and terrain-RAM bus of the crater writer.
// The master side is the environment: it issues crater requests and models the terrain RAM.
// The slave side is the crater writer itself.
interface terrain_crater_writer_if #(
    parameter int ROWS = 480
);
    logic            req_valid;
    logic            req_ready;
    logic [9:0]      req_x;
    logic [9:0]      req_y;
    logic [5:0]      req_radius;
    logic            busy;
    logic            done;
    logic [9:0]      ram_addr;
    logic            ram_rd_en;
    logic [ROWS-1:0] ram_rdata;
    logic            ram_we;
    logic [ROWS-1:0] ram_wdata;

    modport master (
        output req_valid, req_x, req_y, req_radius, ram_rdata,
        input  req_ready, busy, done, ram_addr, ram_rd_en, ram_we, ram_wdata
    );

    modport slave (
        input  req_valid, req_x, req_y, req_radius, ram_rdata,
        output req_ready, busy, done, ram_addr, ram_rd_en, ram_we, ram_wdata
    );
endinterface

// File: rtl/terrain_crater_writer.sv
// Carves a circular crater out of a column-organised terrain bitmap.
// For each column in the crater's x span, the block first searches for the largest
// half-height h with h^2 + dx^2 <= r^2. It then reads the column word and writes it
// back with rows cy-h..cy+h cleared. Bits are only ever cleared, never set.
module terrain_crater_writer #(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic                   clk,
    input  logic                   Reset_n,
    terrain_crater_writer_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC_H = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [11:0] COL_LAST = 12'(COLS - 1);

    logic [2:0]      state_q, state_d;
    logic [9:0]      cx_q, cx_d;
    logic [9:0]      cy_q, cy_d;
    logic [5:0]      r_q, r_d;
    logic [5:0]      h_q, h_d;
    logic [9:0]      x_cur_q, x_cur_d;
    logic [9:0]      x_end_q, x_end_d;
    logic [ROWS-1:0] col_q, col_d;

    logic signed [11:0] x_lo;
    logic [11:0]        x_hi;
    logic [11:0]        x_start;
    logic [11:0]        x_stop;
    logic               skip;
    logic [9:0]         dx;
    logic [12:0]        h_dx_sq;
    logic [12:0]        r_sq;
    logic               outside;
    logic signed [11:0] row_lo;
    logic [11:0]        row_hi;
    logic [ROWS-1:0]    mask;

    // Column span of an incoming request, clipped to the terrain width
    always_comb begin
        x_lo    = $signed({2'b00, bus.req_x}) - $signed({6'd0, bus.req_radius});
        x_hi    = {2'b00, bus.req_x} + {6'd0, bus.req_radius};
        x_start = x_lo[11] ? 12'd0 : $unsigned(x_lo);
        x_stop  = (x_hi > COL_LAST) ? COL_LAST : x_hi;
        skip    = x_start > x_stop;
    end

    // Circle test for the current column; dx never exceeds r, so 13 bits cannot overflow
    always_comb begin
        dx      = (x_cur_q >= cx_q) ? (x_cur_q - cx_q) : (cx_q - x_cur_q);
        h_dx_sq = 13'(h_q) * 13'(h_q) + 13'(dx) * 13'(dx);
        r_sq    = 13'(r_q) * 13'(r_q);
        outside = h_dx_sq > r_sq;
    end

    // Rows to clear in the current column; rows below 0 or above ROWS-1 simply fall outside the word
    always_comb begin
        row_lo = $signed({2'b00, cy_q}) - $signed({6'd0, h_q});
        row_hi = {2'b00, cy_q} + {6'd0, h_q};
        for (int y = 0; y < ROWS; y++) begin
            mask[y] = ($signed(12'(y)) >= row_lo) && (12'(y) <= row_hi);
        end
    end

    // Next-state and datapath update for the crater walk
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        r_d     = r_q;
        h_d     = h_q;
        x_cur_d = x_cur_q;
        x_end_d = x_end_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    cx_d    = bus.req_x;
                    cy_d    = bus.req_y;
                    r_d     = bus.req_radius;
                    h_d     = bus.req_radius;
                    x_cur_d = x_start[9:0];
                    x_end_d = x_stop[9:0];
                    state_d = skip ? S_DONE : S_CALC_H;
                end
            end
            S_CALC_H: begin
                if (outside) begin
                    h_d = h_q - 6'd1;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: begin
                col_d   = bus.ram_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_NEXT;
            S_NEXT: begin
                if (x_cur_q == x_end_q) begin
                    state_d = S_DONE;
                end else begin
                    x_cur_d = x_cur_q + 10'd1;
                    h_d     = r_q;
                    state_d = S_CALC_H;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any crater in progress
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            h_q     <= '0;
            x_cur_q <= '0;
            x_end_q <= '0;
            col_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
            h_q     <= h_d;
            x_cur_q <= x_cur_d;
            x_end_q <= x_end_d;
            col_q   <= col_d;
        end
    end

    // Outputs decode straight from the state, so reset clears them immediately
    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.ram_rd_en = (state_q == S_READ);
    assign bus.ram_we    = (state_q == S_WRITE);
    assign bus.ram_addr  = ((state_q == S_READ) || (state_q == S_WRITE)) ? x_cur_q : '0;
    assign bus.ram_wdata = (state_q == S_WRITE) ? (col_q & ~mask) : '0;
endmodule

// File: tb/tb_terrain_crater_writer.sv
// Directed bench for terrain_crater_writer: a terrain RAM model with a one-cycle read,
// write/read/done counters, and hand-derived column contents for each crater.
module tb_terrain_crater_writer;
    localparam int COLS = 640;
    localparam int ROWS = 480;

    logic clk;
    logic Reset_n;

    terrain_crater_writer_if #(.ROWS(ROWS)) bus ();

    terrain_crater_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ROWS-1:0] mem [COLS];
    int              wr_cnt [COLS];
    int              rd_total, wr_total, wr_oob, both_cnt, done_cnt;
    int              checks, errors;
    int              lat;
    bit              found;
    logic [ROWS-1:0] all_ones;

    // Hand-derived cleared row ranges per column
    int t1_lo [7] = '{200, 198, 198, 197, 198, 198, 200};
    int t1_hi [7] = '{200, 202, 202, 203, 202, 202, 200};
    int t2_hi [6] = '{5, 4, 4, 4, 3, 0};
    int t3_lo [3] = '{479, 478, 477};

    // Terrain RAM: registered read, write on the strobe edge; also logs bus activity
    always @(posedge clk) begin
        if (bus.ram_rd_en && bus.ram_we) both_cnt++;
        if (bus.done) done_cnt++;
        if (bus.ram_rd_en) begin
            rd_total++;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
        if (bus.ram_we) begin
            wr_total++;
            if (int'(bus.ram_addr) < COLS) begin
                mem[bus.ram_addr] = bus.ram_wdata;
                wr_cnt[bus.ram_addr]++;
            end else begin
                wr_oob++;
            end
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROWS-1:0] cleared(input int lo, input int hi);
        logic [ROWS-1:0] w;
        w = '1;
        for (int i = lo; i <= hi; i++) w[i] = 1'b0;
        return w;
    endfunction

    task automatic clear_env();
        for (int i = 0; i < COLS; i++) begin
            mem[i]    = '1;
            wr_cnt[i] = 0;
        end
        rd_total = 0;
        wr_total = 0;
        wr_oob   = 0;
        both_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic check_col(input int col, input int lo, input int hi);
        check($sformatf("col%0d_data", col), mem[col], cleared(lo, hi));
        check($sformatf("col%0d_writes", col), wr_cnt[col], 1);
    endtask

    // Issue one request; latency counts cycles from the accept edge to the done pulse.
    // With hold set, req_valid stays high with different fields while the block is busy.
    task automatic run_req(input logic [9:0] x, input logic [9:0] y, input logic [5:0] r,
                           input bit hold, output int latency);
        @(negedge clk);
        check("ready_before_req", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_x      = x;
        bus.req_y      = y;
        bus.req_radius = r;
        @(posedge clk);
        #1;
        if (hold) begin
            bus.req_x      = 10'd500;
            bus.req_y      = 10'd5;
            bus.req_radius = 6'd1;
        end else begin
            bus.req_valid = 1'b0;
        end
        latency = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (bus.done) begin
                latency       = n;
                bus.req_valid = 1'b0;
                break;
            end
        end
        if (latency < 0) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("ready_after_done", bus.req_ready, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        all_ones = '1;
        Reset_n = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_radius = '0;
        clear_env();
        #1 Reset_n = 1'b0;
        #1;
        check("rst_ready", bus.req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd_en", bus.ram_rd_en, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_wdata", bus.ram_wdata, 0);
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;

        // Interior crater, request held high with altered fields while busy
        clear_env();
        run_req(10'd100, 10'd200, 6'd3, 1'b1, lat);
        check("t1_latency", lat, 46);
        for (int i = 0; i < 7; i++) check_col(97 + i, t1_lo[i], t1_hi[i]);
        check("t1_col96", mem[96], all_ones);
        check("t1_col104", mem[104], all_ones);
        check("t1_writes", wr_total, 7);
        check("t1_reads", rd_total, 7);
        check("t1_col500_writes", wr_cnt[500], 0);
        check("t1_done_count", done_cnt, 1);
        check("t1_rd_we_overlap", both_cnt, 0);

        // Top-left corner: columns and rows below zero clipped
        clear_env();
        run_req(10'd0, 10'd0, 6'd5, 1'b0, lat);
        check("t2_latency", lat, 41);
        for (int i = 0; i < 6; i++) check_col(i, 0, t2_hi[i]);
        check("t2_col6", mem[6], all_ones);
        check("t2_writes", wr_total, 6);
        check("t2_oob_writes", wr_oob, 0);
        check("t2_done_count", done_cnt, 1);

        // Bottom-right corner: columns and rows above the edge clipped
        clear_env();
        run_req(10'd639, 10'd479, 6'd2, 1'b0, lat);
        check("t3_latency", lat, 19);
        for (int i = 0; i < 3; i++) check_col(637 + i, t3_lo[i], 479);
        check("t3_col636", mem[636], all_ones);
        check("t3_writes", wr_total, 3);
        check("t3_oob_writes", wr_oob, 0);

        // Crater entirely right of the terrain: no RAM traffic
        clear_env();
        run_req(10'd700, 10'd0, 6'd10, 1'b0, lat);
        check("t4_latency", lat, 1);
        check("t4_reads", rd_total, 0);
        check("t4_writes", wr_total, 0);
        check("t4_done_count", done_cnt, 1);

        // Zero radius: a single bit in a single column
        clear_env();
        run_req(10'd10, 10'd10, 6'd0, 1'b0, lat);
        check("t5_latency", lat, 6);
        check_col(10, 10, 10);
        check("t5_col9", mem[9], all_ones);
        check("t5_col11", mem[11], all_ones);
        check("t5_writes", wr_total, 1);

        // Reset during the second column's write
        clear_env();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_x      = 10'd300;
        bus.req_y      = 10'd100;
        bus.req_radius = 6'd2;
        @(posedge clk);
        #1;
        bus.req_x = 10'd50;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.ram_we && bus.ram_addr == 10'd299) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_second_write_seen", found, 1);
        Reset_n = 1'b0;
        #1;
        check("t6_we_after_rst", bus.ram_we, 0);
        check("t6_busy_after_rst", bus.busy, 0);
        check("t6_ready_after_rst", bus.req_ready, 1);
        check("t6_addr_after_rst", bus.ram_addr, 0);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_done_count", done_cnt, 0);
        check("t6_writes", wr_total, 1);
        check_col(298, 100, 100);
        check("t6_col299", mem[299], all_ones);
        check("t6_col299_writes", wr_cnt[299], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
